// File: rtl/secure_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : secure_scan_pkg
// Description : Shared types and constants for the key-gated scan register
//               bank: unlock FSM state encoding and default key settings.
// Revision    : 1.0 - initial release
// ============================================================================
package secure_scan_pkg;

    // Unlock FSM states; 2-bit encoding with explicit values
    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_BRICKED  = 2'd3
    } state_t;

    // Default unlock key length and value
    localparam int                 c_KEY_W = 8;
    localparam logic [c_KEY_W-1:0] c_KEY   = 8'hA5;

endpackage : secure_scan_pkg
`default_nettype wire

// File: rtl/scan_key_fsm.sv
`default_nettype none
// ============================================================================
// Module      : scan_key_fsm
// Description : Key-unlock state machine guarding the scan chain. Collects a
//               serial key while SE is high, checks it one cycle after SE
//               falls, zeroises the data on success and bricks scan access
//               after MAX_FAIL wrong keys.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_key_fsm
    import secure_scan_pkg::*;
#(
    parameter int               KEY_W    = c_KEY_W,
    parameter logic [KEY_W-1:0] KEY      = KEY_W'(c_KEY),
    parameter int               MAX_FAIL = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_se,
    input  logic i_si,
    output logic o_unlocked,
    output logic o_zeroise,
    output logic o_hold
);

    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_se_q;
    logic [KEY_W-1:0]      r_key_sr;
    logic [KEY_W-1:0]      w_key_nxt;
    logic [KEY_W-1:0]      w_key_shift;
    logic [c_FAIL_W-1:0]   r_fail_cnt;
    logic [c_FAIL_W-1:0]   w_fail_nxt;
    logic [c_FAIL_W-1:0]   w_fail_inc;

    // Key bits arrive MSB first, so new bits enter at the LSB end
    generate
        if (KEY_W == 1) begin : g_key_single
            assign w_key_shift = i_si;
        end else begin : g_key_multi
            assign w_key_shift = {r_key_sr[KEY_W-2:0], i_si};
        end
    endgenerate

    // Fail counter saturates instead of wrapping
    assign w_fail_inc = (r_fail_cnt == c_FAIL_W'(MAX_FAIL)) ? r_fail_cnt
                                                            : r_fail_cnt + c_FAIL_W'(1);

    // State, key shifter, fail counter and SE history registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_LOCKED;
            r_se_q     <= 1'b0;
            r_key_sr   <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_se_q     <= i_se;
            r_key_sr   <= w_key_nxt;
            r_fail_cnt <= w_fail_nxt;
        end
    end

    // Next-state decode plus pipeline hold / zeroise requests
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key_sr;
        w_fail_nxt  = r_fail_cnt;
        o_zeroise   = 1'b0;
        o_hold      = 1'b0;
        case (r_state)
            ST_LOCKED: begin
                if (i_se) begin
                    w_key_nxt = w_key_shift;
                    o_hold    = 1'b1;
                end else if (r_se_q) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                o_hold    = 1'b1;
                w_key_nxt = '0;
                if (r_key_sr == KEY) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_fail_nxt  = '0;
                    o_zeroise   = 1'b1;
                end else begin
                    w_fail_nxt  = w_fail_inc;
                    w_state_nxt = (w_fail_inc == c_FAIL_W'(MAX_FAIL)) ? ST_BRICKED
                                                                      : ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                w_state_nxt = ST_UNLOCKED;
            end
            ST_BRICKED: begin
                w_state_nxt = ST_BRICKED;
            end
            default: begin
                w_state_nxt = ST_LOCKED;
            end
        endcase
    end

    assign o_unlocked = (r_state == ST_UNLOCKED);

endmodule : scan_key_fsm
`default_nettype wire

// File: rtl/secure_scan_reg.sv
`default_nettype none
// ============================================================================
// Module      : secure_scan_reg
// Description : STAGES x WIDTH pipeline register bank with clock enable and a
//               scan chain through every bit. Scan access is only granted
//               after a serial key unlock, which also clears all data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module secure_scan_reg
    import secure_scan_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               STAGES   = 2,
    parameter int               KEY_W    = c_KEY_W,
    parameter logic [KEY_W-1:0] KEY      = KEY_W'(c_KEY),
    parameter int               MAX_FAIL = 3
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
    output logic             LOCKED
);

    localparam int c_BITS = WIDTH * STAGES;

    // Stage k occupies bits [k*WIDTH +: WIDTH]; the scan chain is simply the
    // whole vector shifted by one bit towards the MSB.
    logic [c_BITS-1:0] r_chain;
    logic [c_BITS-1:0] w_func_nxt;
    logic [c_BITS-1:0] w_scan_nxt;
    logic              w_unlocked;
    logic              w_zeroise;
    logic              w_hold;

    scan_key_fsm #(
        .KEY_W    (KEY_W),
        .KEY      (KEY),
        .MAX_FAIL (MAX_FAIL)
    ) u_key_fsm (
        .i_clk      (CK),
        .i_rst_n    (RST),
        .i_se       (SE),
        .i_si       (SI),
        .o_unlocked (w_unlocked),
        .o_zeroise  (w_zeroise),
        .o_hold     (w_hold)
    );

    generate
        if (STAGES == 1) begin : g_func_single
            assign w_func_nxt = D;
        end else begin : g_func_multi
            assign w_func_nxt = {r_chain[c_BITS-WIDTH-1:0], D};
        end
        if (c_BITS == 1) begin : g_scan_single
            assign w_scan_nxt = SI;
        end else begin : g_scan_multi
            assign w_scan_nxt = {r_chain[c_BITS-2:0], SI};
        end
    endgenerate

    // Register bank: zeroise beats scan shift, scan shift beats functional load
    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            r_chain <= '0;
        end else if (w_zeroise) begin
            r_chain <= '0;
        end else if (w_unlocked && SE) begin
            r_chain <= w_scan_nxt;
        end else if (!w_hold && EN) begin
            r_chain <= w_func_nxt;
        end
    end

    assign Q      = r_chain[c_BITS-1 -: WIDTH];
    assign SO     = w_unlocked & r_chain[c_BITS-1];
    assign LOCKED = ~w_unlocked;

endmodule : secure_scan_reg
`default_nettype wire
